// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, ALUOp and state encodings shared by the multicycle control unit and ALU control
package mips_ctrl_pkg;
  localparam int OPC_W = 6;
  localparam int ALUOP_W = 3;
  localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPC_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [ALUOP_W-1:0] ALU_R   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;
  function automatic state_t decode_target(input logic [OPC_W-1:0] op);
    return (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op == OP_R) ? S_EXECUTE :
           (op == OP_BEQ) ? S_BRANCH :
           (op == OP_J) ? S_JUMP :
           (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) ? S_IMM_EXEC :
           S_FETCH;
  endfunction
  function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPC_W-1:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS main control; sequences fetch/decode/execute/memory/writeback and drives datapath strobes, selects and ALUOp
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state_o
);
  state_t state, state_n;
  logic [OPC_W-1:0] op_q;
  assign state_o = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:     state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_n = decode_target(opcode);
      S_MEM_ADDR:  state_n = op_q == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_n = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_n = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_n = S_R_WB;
      S_IMM_EXEC:  state_n = S_IMM_WB;
      default:     state_n = S_FETCH;
    endcase
  end
  // Defaults double as the reset values, so rst simply skips the state decode.
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_source = 2'b00;
    alu_op = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal_op = decode_target(opcode) == S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d = 1'b1;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op = ALU_R;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source = 2'b01;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_source = 2'b10;
          instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op = imm_alu_op(op_q);
        end
        S_IMM_WB: begin
          reg_write = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction streams checked against a per-instruction cycle-plan reference model
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic [22:0] obs;
  int total = 0;
  int bad = 0;
  typedef struct {int st; bit mr;} cyc_t;
  localparam logic [22:0] RST_VEC = 23'h000040;
  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b001000, 6'b001100, 6'b001101, 6'b001010};

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done,
                illegal_op, state_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Expected output word for one cycle of an instruction, from the per-state output table.
  function automatic logic [22:0] expect_out(input int st, input bit mr, input logic [5:0] op);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
    logic done = 0, ill = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] aop = 3'b001;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1: begin asb = 2'b11; ill = !is_legal(op); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; done = 1; end
      5: begin mwr = 1; iod = 1; done = mr; end
      6: begin asa = 1; aop = 3'b000; end
      7: begin rw = 1; rdst = 1; done = 1; end
      8: begin asa = 1; aop = 3'b010; pwc = 1; pcs = 2'b01; done = 1; end
      9: begin pw = 1; pcs = 2'b10; done = 1; end
      10: begin
        asa = 1; asb = 2'b10;
        aop = op == 6'b001100 ? 3'b011 : op == 6'b001101 ? 3'b100 : op == 6'b001010 ? 3'b101 : 3'b001;
      end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, done, ill, 4'(st)};
  endfunction

  task automatic drive_cycle(input cyc_t c, input logic [5:0] op, inout int n, inout int done_at);
    n++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = c.mr;
    opcode = c.st == 1 ? op : 6'($urandom);
    @(negedge clk);
    check("outputs", 32'(obs), 32'(expect_out(c.st, c.mr, op)));
    if (done_at == 0 && (instr_done || illegal_op)) done_at = n;
  endtask

  // Plans the state sequence of one instruction with fw fetch waits and mw memory waits.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    cyc_t q[$];
    int n = 0, done_at = 0, lat;
    int mem_st = op == 6'b100011 ? 3 : 5;
    for (int i = 0; i < fw; i++) q.push_back('{st: 0, mr: 1'b0});
    q.push_back('{st: 0, mr: 1'b1});
    q.push_back('{st: 1, mr: rb()});
    lat = 2 + fw;
    if (op == 6'b100011 || op == 6'b101011) begin
      q.push_back('{st: 2, mr: rb()});
      for (int i = 0; i < mw; i++) q.push_back('{st: mem_st, mr: 1'b0});
      q.push_back('{st: mem_st, mr: 1'b1});
      if (op == 6'b100011) q.push_back('{st: 4, mr: rb()});
      lat += mw + (op == 6'b100011 ? 3 : 2);
    end else if (op == 6'b000000) begin
      q.push_back('{st: 6, mr: rb()});
      q.push_back('{st: 7, mr: rb()});
      lat += 2;
    end else if (op == 6'b000100 || op == 6'b000010) begin
      q.push_back('{st: op == 6'b000100 ? 8 : 9, mr: rb()});
      lat += 1;
    end else if (is_legal(op)) begin
      q.push_back('{st: 10, mr: rb()});
      q.push_back('{st: 11, mr: rb()});
      lat += 2;
    end else lat -= 0;
    foreach (q[i]) drive_cycle(q[i], op, n, done_at);
    check(is_legal(op) ? "latency" : "illegal_cycle", 32'(done_at), 32'(lat));
  endtask

  // Starts a sw and asserts rst for 3 cycles as soon as MEM_WRITE is entered.
  task automatic reset_mid_write();
    int n = 0, done_at = 0;
    drive_cycle('{st: 0, mr: 1'b1}, 6'b101011, n, done_at);
    drive_cycle('{st: 1, mr: rb()}, 6'b101011, n, done_at);
    drive_cycle('{st: 2, mr: rb()}, 6'b101011, n, done_at);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = rb();
      opcode = 6'($urandom);
      @(negedge clk);
      check("rst_strobes", 32'(obs[22:4]), 32'(RST_VEC[22:4]));
    end
    check("rst_no_done", 32'(done_at), 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", 32'(obs), 32'(RST_VEC));
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b001010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b101011, 1, 1);
    run_instr(6'b000010, 2, 0);
    reset_mid_write();
    run_instr(6'b000000, 0, 0);
    for (int k = 0; k < 300; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 9) op = legal_ops[r];
      else do op = 6'($urandom); while (is_legal(op));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
